// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice plus a carry flip-flop,
// processing one bit per clock LSB first, with a one-cycle valid strobe on completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] op1_sh;
  logic [WIDTH-1:0] op2_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             busy_reg;
  logic             valid_reg;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_sh_next;

  full_adder u_fa (
    .a     (op1_sh[0]),
    .b     (op2_sh[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Widening before the shift keeps the slice legal even when WIDTH is 1.
  assign sum_ext     = {fa_sum, sum_sh};
  assign sum_sh_next = sum_ext[WIDTH:1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      op1_sh        <= '0;
      op2_sh        <= '0;
      sum_sh        <= '0;
      carry_q       <= 1'b0;
      cnt           <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            op1_sh    <= i_operand1;
            op2_sh    <= i_operand2;
            carry_q   <= i_carry;
            sum_sh    <= '0;
            cnt       <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          op1_sh  <= op1_sh >> 1;
          op2_sh  <= op2_sh >> 1;
          sum_sh  <= sum_sh_next;
          carry_q <= fa_carry;
          cnt     <= cnt + CNT_W'(1);
          // Final bit step: publish the sum including the bit just computed.
          if (cnt == LAST_BIT) begin
            result_reg    <= sum_sh_next;
            carry_out_reg <= fa_carry;
            valid_reg     <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_busy   = busy_reg;
  assign o_valid  = valid_reg;
  assign o_result = result_reg;
  assign o_carry  = carry_out_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, 2 and 1 with hand-computed sums.

module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic       start8, c8;
  logic [7:0] a8, b8;
  logic       busy8, valid8, co8;
  logic [7:0] r8;

  logic       start2, c2;
  logic [1:0] a2, b2;
  logic       busy2, valid2, co2;
  logic [1:0] r2;

  logic       start1, c1;
  logic [0:0] a1, b1;
  logic       busy1, valid1, co1;
  logic [0:0] r1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
    .i_operand1(a8), .i_operand2(b8), .i_carry(c8),
    .o_busy(busy8), .o_valid(valid8), .o_result(r8), .o_carry(co8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .i_operand1(a2), .i_operand2(b2), .i_carry(c2),
    .o_busy(busy2), .o_valid(valid2), .o_result(r2), .o_carry(co2)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
    .i_operand1(a1), .i_operand2(b1), .i_carry(c1),
    .o_busy(busy1), .o_valid(valid1), .o_result(r1), .o_carry(co1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation: start sampled at E0, valid expected after E8 only.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] er, input logic ec, input string tag);
    int bad_valid;
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk({tag, "_busy_e0"}, busy8, 1);
    bad_valid = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (valid8 !== 1'b0 || busy8 !== 1'b1) bad_valid++;
    end
    chk({tag, "_early_valid"}, bad_valid, 0);
    step();
    chk({tag, "_valid"}, valid8, 1);
    chk({tag, "_result"}, r8, er);
    chk({tag, "_carry"}, co8, ec);
    step();
    chk({tag, "_valid_one_cycle"}, valid8, 0);
    chk({tag, "_busy_end"}, busy8, 0);
    chk({tag, "_result_hold"}, r8, er);
    $display("op W8 %s: %02h+%02h+%0d -> result=%02h carry=%0d", tag, a, b, c, r8, co8);
  endtask

  logic [2:0] prev2;
  logic [1:0] prev1;
  int         pulse_cyc[$];
  int         cyc;

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;

    // Reset then idle
    #2;
    chk("rst_busy", busy8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_result", r8, 0);
    chk("rst_carry", co8, 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("idle_busy", busy8, 0);
    chk("idle_valid", valid8, 0);
    chk("idle_result", r8, 0);
    chk("idle_carry", co8, 0);
    $display("reset/idle checked");

    // Basic sums
    run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "sum_3c_42");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "sum_ff_01");
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "sum_a5_5a_c");

    // Capture isolation: operands and start change during RUN
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int i = 1; i <= 8; i++) step();
    start8 = 1'b0;
    chk("iso_valid", valid8, 1);
    chk("iso_result", r8, 8'h30);
    chk("iso_carry", co8, 0);
    step();
    chk("iso_busy_fall", busy8, 0);
    step();
    chk("iso_no_second_op", busy8, 0);
    $display("op W8 isolation: result=%02h carry=%0d", r8, co8);

    // Back-to-back with start held high
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b1; start8 = 1'b1;
    step();
    for (cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (valid8 === 1'b1) begin
        pulse_cyc.push_back(cyc);
        chk("b2b_result", r8, 8'h03);
        chk("b2b_carry", co8, 0);
        $display("op W8 back-to-back pulse at cycle %0d result=%02h", cyc, r8);
      end
    end
    start8 = 1'b0;
    chk("b2b_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("b2b_first", pulse_cyc[0], 8);
      chk("b2b_gap1", pulse_cyc[1] - pulse_cyc[0], 10);
      chk("b2b_gap2", pulse_cyc[2] - pulse_cyc[1], 10);
    end
    repeat (12) step();
    chk("b2b_drained", busy8, 0);

    // Reset mid-operation at bit step 4
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_valid", valid8, 0);
    chk("mid_rst_result", r8, 0);
    chk("mid_rst_carry", co8, 0);
    repeat (6) begin
      step();
      chk("mid_rst_no_valid", valid8, 0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy8, 0);
    $display("reset mid-operation checked");
    run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "post_rst_2_3");

    // Exhaustive WIDTH=2
    prev2 = 3'd0;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        for (int z = 0; z < 2; z++) begin
          a2 = 2'(x); b2 = 2'(y); c2 = 1'(z); start2 = 1'b1;
          step();
          start2 = 1'b0;
          chk("w2_busy", busy2, 1);
          chk("w2_stable_e0", {co2, r2}, prev2);
          step();
          chk("w2_early_valid", valid2, 0);
          chk("w2_stable_e1", {co2, r2}, prev2);
          step();
          chk("w2_valid", valid2, 1);
          chk("w2_sum", {co2, r2}, 32'(x + y + z));
          prev2 = 3'(x + y + z);
          step();
          chk("w2_valid_drop", valid2, 0);
          chk("w2_idle", busy2, 0);
          $display("op W2 %0d+%0d+%0d -> carry=%0d result=%0d", x, y, z, co2, r2);
        end
      end
    end

    // Exhaustive WIDTH=1
    prev1 = 2'd0;
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        for (int z = 0; z < 2; z++) begin
          a1 = 1'(x); b1 = 1'(y); c1 = 1'(z); start1 = 1'b1;
          step();
          start1 = 1'b0;
          chk("w1_busy", busy1, 1);
          chk("w1_early_valid", valid1, 0);
          chk("w1_stable_e0", {co1, r1}, prev1);
          step();
          chk("w1_valid", valid1, 1);
          chk("w1_sum", {co1, r1}, 32'(x + y + z));
          prev1 = 2'(x + y + z);
          step();
          chk("w1_valid_drop", valid1, 0);
          chk("w1_idle", busy1, 0);
          $display("op W1 %0d+%0d+%0d -> carry=%0d result=%0d", x, y, z, co1, r1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
